// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   DEFAULT_ADDR_WIDTH  - default PC / instruction memory address width
//   DEFAULT_INSTR_WIDTH - default instruction word width
//   DEFAULT_RESET_PC    - default PC value after reset
//   fetch_entry_t       - one prefetch queue entry {pc, instr} at default widths
package fetch_pkg;

    localparam int DEFAULT_ADDR_WIDTH  = 16;
    localparam int DEFAULT_INSTR_WIDTH = 20;
    localparam int DEFAULT_RESET_PC    = 0;

    typedef struct packed {
        logic [DEFAULT_ADDR_WIDTH-1:0]  pc;
        logic [DEFAULT_INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry prefetch FIFO holding {pc, instr} entries.
// Circular read/write pointers wrap explicitly at DEPTH, so DEPTH need not be
// a power of two. flush_i empties the queue on the next rising edge and wins
// over a simultaneous push/pop.
//   clock_i, reset_i   - clock, asynchronous active-high reset
//   flush_i            - synchronous clear of all entries
//   push_i, push_data_i- write one entry at the tail
//   pop_i              - drop the head entry
//   head_o             - entry at the head (stale contents when empty)
//   count_o            - number of stored entries, 0..DEPTH
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  entry_t                       push_data_i,
    input  logic                         pop_i,
    output entry_t                       head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Guards keep the pointers coherent even if a caller misbehaves; in normal
    // use the fetch credit rule never pushes into a full queue.
    assign do_push = push_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Pipelined instruction fetch: owns the PC, issues at most one read per cycle
// to a synchronous instruction memory (data returns the cycle after the
// request) and buffers returned words in a DEPTH-entry prefetch queue.
//   clock, reset          - clock, asynchronous active-high reset
//   stall                 - decode cannot accept the head this cycle
//   jumpEnable/jumpAddress- redirect fetch; squashes queue and in-flight word
//   imemAddress/imemRead  - memory request
//   imemData              - memory response, valid the cycle after imemRead
//   instructionOut/pcOut  - queue head presented to decode
//   validOut              - head is valid and not being squashed
//
// Handshake with decode: the head transfers on a rising edge exactly when
// validOut is high and stall is low. validOut never depends on stall.
module instruction_fetch_stage
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
    parameter int DEPTH       = 4,
    parameter int RESET_PC    = DEFAULT_RESET_PC
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   jumpEnable,
    input  logic [ADDR_WIDTH-1:0]  jumpAddress,
    output logic [ADDR_WIDTH-1:0]  imemAddress,
    output logic                   imemRead,
    input  logic [INSTR_WIDTH-1:0] imemData,
    output logic [INSTR_WIDTH-1:0] instructionOut,
    output logic [ADDR_WIDTH-1:0]  pcOut,
    output logic                   validOut
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  inflight_q, inflight_d;
    logic [CW-1:0]         count;
    logic [CW:0]           occupancy;
    logic                  pop;
    logic                  push;
    logic                  issue;
    entry_t                head;
    entry_t                push_entry;

    assign validOut = (count != '0) && !jumpEnable;
    assign pop      = validOut && !stall;

    // Credit rule: entries held + the word already in flight - the entry
    // leaving now must leave room for the word requested this cycle.
    assign occupancy = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);

    // A jump kills the response arriving this cycle; it belongs to the old path.
    assign push       = inflight_q && !jumpEnable;
    assign push_entry = '{pc: req_pc_q, instr: imemData};

    always_comb begin
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        inflight_d  = 1'b0;
        imemAddress = pc_q;
        issue       = 1'b0;
        if (jumpEnable) begin
            imemAddress = jumpAddress;
            issue       = 1'b1;
            pc_d        = jumpAddress + ADDR_WIDTH'(1);
            req_pc_d    = jumpAddress;
            inflight_d  = 1'b1;
        end else if (occupancy < (CW+1)'(DEPTH)) begin
            issue       = 1'b1;
            pc_d        = pc_q + ADDR_WIDTH'(1);
            req_pc_d    = pc_q;
            inflight_d  = 1'b1;
        end
    end

    assign imemRead = issue && !reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q       <= ADDR_WIDTH'(RESET_PC);
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clock_i     (clock),
        .reset_i     (reset),
        .flush_i     (jumpEnable),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    assign instructionOut = head.instr;
    assign pcOut          = head.pc;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

    localparam int AW    = 16;
    localparam int IW    = 20;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          stall = 1'b0;
    logic          jumpEnable = 1'b0;
    logic [AW-1:0] jumpAddress = '0;
    logic [AW-1:0] imemAddress;
    logic          imemRead;
    logic [IW-1:0] imemData;
    logic [IW-1:0] instructionOut;
    logic [AW-1:0] pcOut;
    logic          validOut;

    int            asserts = 0;
    int            failures = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] head_pc;

    instruction_fetch_stage #(
        .ADDR_WIDTH  (AW),
        .INSTR_WIDTH (IW),
        .DEPTH       (DEPTH),
        .RESET_PC    (0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .jumpEnable     (jumpEnable),
        .jumpAddress    (jumpAddress),
        .imemAddress    (imemAddress),
        .imemRead       (imemRead),
        .imemData       (imemData),
        .instructionOut (instructionOut),
        .pcOut          (pcOut),
        .validOut       (validOut)
    );

    // Clock / reset block
    always #5 clock = ~clock;

    // Synchronous instruction memory model: word = address ^ 0xABCDE
    always @(posedge clock) begin
        if (imemRead) imemData <= {4'h0, imemAddress} ^ 20'hABCDE;
    end

    function automatic logic [IW-1:0] exp_instr(input logic [AW-1:0] a);
        return {4'h0, a} ^ 20'hABCDE;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; jumpEnable = 1'b0;
        #2;
        asserts++; if (validOut !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", validOut); end
        asserts++; if (pcOut !== 16'h0) begin failures++; $display("FAIL reset_pc: got %h want 0000", pcOut); end
        asserts++; if (instructionOut !== 20'h0) begin failures++; $display("FAIL reset_instr: got %h want 00000", instructionOut); end
        asserts++; if (imemRead !== 1'b0) begin failures++; $display("FAIL reset_imemread: got %b want 0", imemRead); end
        step(); step();
        reset = 1'b0;
        #1;
        asserts++; if (imemRead !== 1'b1) begin failures++; $display("FAIL first_issue_read: got %b want 1", imemRead); end
        asserts++; if (imemAddress !== 16'h0) begin failures++; $display("FAIL first_issue_addr: got %h want 0000", imemAddress); end
        step();
        asserts++; if (validOut !== 1'b0) begin failures++; $display("FAIL latency_r1_valid: got %b want 0", validOut); end
        step();
        asserts++; if (validOut !== 1'b1) begin failures++; $display("FAIL latency_r2_valid: got %b want 1", validOut); end
        asserts++; if (pcOut !== 16'h0) begin failures++; $display("FAIL latency_r2_pc: got %h want 0000", pcOut); end
        asserts++; if (instructionOut !== 20'hABCDE) begin failures++; $display("FAIL latency_r2_instr: got %h want abcde", instructionOut); end
        head_pc = 16'h0;
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 16; i++) begin
            asserts++; if (validOut !== 1'b1) begin failures++; $display("FAIL free_valid[%0d]: got %b want 1", i, validOut); end
            asserts++; if (pcOut !== head_pc) begin failures++; $display("FAIL free_pc[%0d]: got %h want %h", i, pcOut, head_pc); end
            asserts++; if (instructionOut !== exp_instr(head_pc)) begin failures++; $display("FAIL free_instr[%0d]: got %h want %h", i, instructionOut, exp_instr(head_pc)); end
            head_pc = head_pc + 16'h1;
            step();
        end
    endtask

    task automatic test_stall();
        logic [AW-1:0] h;
        logic [AW-1:0] e;
        h = head_pc;
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            asserts++; if (validOut !== 1'b1 || pcOut !== h) begin failures++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h want v=1 pc=%h", i, validOut, pcOut, h); end
            step();
        end
        asserts++; if (imemRead !== 1'b0) begin failures++; $display("FAIL stall_full_read: got %b want 0", imemRead); end
        // Exactly DEPTH entries buffered means the PC sits DEPTH past the head.
        asserts++; if (imemAddress !== h + 16'(DEPTH)) begin failures++; $display("FAIL stall_full_pc: got %h want %h", imemAddress, h + 16'(DEPTH)); end
        stall = 1'b0;
        for (int i = 0; i < 10; i++) exp_q.push_back(h + 16'(i));
        for (int i = 0; i < 10; i++) begin
            e = exp_q.pop_front();
            asserts++; if (validOut !== 1'b1 || pcOut !== e || instructionOut !== exp_instr(e)) begin
                failures++; $display("FAIL stall_release[%0d]: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", i, validOut, pcOut, instructionOut, e, exp_instr(e));
            end
            step();
        end
        head_pc = h + 16'd10;
    endtask

    task automatic test_jump();
        jumpEnable = 1'b1; jumpAddress = 16'h0F1F;
        #1;
        asserts++; if (validOut !== 1'b0) begin failures++; $display("FAIL jump_j_valid: got %b want 0", validOut); end
        asserts++; if (imemRead !== 1'b1 || imemAddress !== 16'h0F1F) begin failures++; $display("FAIL jump_j_req: got rd=%b a=%h want rd=1 a=0f1f", imemRead, imemAddress); end
        step();
        jumpEnable = 1'b0;
        #1;
        asserts++; if (validOut !== 1'b0) begin failures++; $display("FAIL jump_j1_valid: got %b want 0", validOut); end
        asserts++; if (imemAddress !== 16'h0F20) begin failures++; $display("FAIL jump_j1_addr: got %h want 0f20", imemAddress); end
        step();
        asserts++; if (validOut !== 1'b1 || pcOut !== 16'h0F1F || instructionOut !== exp_instr(16'h0F1F)) begin
            failures++; $display("FAIL jump_j2_head: got v=%b pc=%h ins=%h want v=1 pc=0f1f ins=%h", validOut, pcOut, instructionOut, exp_instr(16'h0F1F));
        end
        step();
        asserts++; if (validOut !== 1'b1 || pcOut !== 16'h0F20) begin failures++; $display("FAIL jump_j3_head: got v=%b pc=%h want v=1 pc=0f20", validOut, pcOut); end
    endtask

    task automatic test_jump_stall_full();
        stall = 1'b1;
        for (int i = 0; i < 8; i++) step();
        asserts++; if (imemRead !== 1'b0) begin failures++; $display("FAIL jsf_full_read: got %b want 0", imemRead); end
        jumpEnable = 1'b1; jumpAddress = 16'h1234;
        #1;
        asserts++; if (validOut !== 1'b0 || imemRead !== 1'b1 || imemAddress !== 16'h1234) begin
            failures++; $display("FAIL jsf_j: got v=%b rd=%b a=%h want v=0 rd=1 a=1234", validOut, imemRead, imemAddress);
        end
        step();
        jumpEnable = 1'b0; stall = 1'b0;
        #1;
        asserts++; if (validOut !== 1'b0) begin failures++; $display("FAIL jsf_j1_valid: got %b want 0", validOut); end
        step();
        asserts++; if (validOut !== 1'b1 || pcOut !== 16'h1234) begin failures++; $display("FAIL jsf_j2_head: got v=%b pc=%h want v=1 pc=1234", validOut, pcOut); end
        step();
        asserts++; if (validOut !== 1'b1 || pcOut !== 16'h1235) begin failures++; $display("FAIL jsf_j3_head: got v=%b pc=%h want v=1 pc=1235", validOut, pcOut); end
    endtask

    task automatic test_wrap();
        jumpEnable = 1'b1; jumpAddress = 16'hFFFE;
        step();
        jumpEnable = 1'b0;
        step();
        asserts++; if (validOut !== 1'b1 || pcOut !== 16'hFFFE) begin failures++; $display("FAIL wrap_0: got v=%b pc=%h want v=1 pc=fffe", validOut, pcOut); end
        step();
        asserts++; if (validOut !== 1'b1 || pcOut !== 16'hFFFF) begin failures++; $display("FAIL wrap_1: got v=%b pc=%h want v=1 pc=ffff", validOut, pcOut); end
        step();
        asserts++; if (validOut !== 1'b1 || pcOut !== 16'h0000 || instructionOut !== 20'hABCDE) begin
            failures++; $display("FAIL wrap_2: got v=%b pc=%h ins=%h want v=1 pc=0000 ins=abcde", validOut, pcOut, instructionOut);
        end
    endtask

    task automatic test_reset_mid();
        stall = 1'b1;
        step(); step();
        asserts++; if (validOut !== 1'b1) begin failures++; $display("FAIL rmid_pre_valid: got %b want 1", validOut); end
        #2;
        reset = 1'b1;
        #1;
        asserts++; if (validOut !== 1'b0 || pcOut !== 16'h0 || instructionOut !== 20'h0) begin
            failures++; $display("FAIL rmid_async_clear: got v=%b pc=%h ins=%h want v=0 pc=0000 ins=00000", validOut, pcOut, instructionOut);
        end
        asserts++; if (imemRead !== 1'b0) begin failures++; $display("FAIL rmid_read: got %b want 0", imemRead); end
        step();
        reset = 1'b0; stall = 1'b0;
        #1;
        asserts++; if (imemRead !== 1'b1 || imemAddress !== 16'h0) begin failures++; $display("FAIL rmid_restart_req: got rd=%b a=%h want rd=1 a=0000", imemRead, imemAddress); end
        step();
        asserts++; if (validOut !== 1'b0) begin failures++; $display("FAIL rmid_r1_valid: got %b want 0 (stale entry)", validOut); end
        step();
        asserts++; if (validOut !== 1'b1 || pcOut !== 16'h0 || instructionOut !== 20'hABCDE) begin
            failures++; $display("FAIL rmid_r2_head: got v=%b pc=%h ins=%h want v=1 pc=0000 ins=abcde", validOut, pcOut, instructionOut);
        end
        step();
        asserts++; if (validOut !== 1'b1 || pcOut !== 16'h1) begin failures++; $display("FAIL rmid_r3_head: got v=%b pc=%h want v=1 pc=0001", validOut, pcOut); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_jump();
        test_jump_stall_full();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
